// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words from a
// valid/ready byte stream and writes them to instruction memory from address 0.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         asm_q, asm_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic                byte_ready_q, byte_ready_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    len_clamp;

  // Session length is clamped to the memory depth so the address never wraps.
  always_comb begin
    len_clamp = num_words;
    if (num_words > CNT_W'(DEPTH)) begin
      len_clamp = CNT_W'(DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_cnt_q   <= word_cnt_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and datapath; abort wins over both byte transfer and write.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    word_cnt_d = word_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = len_clamp;
          word_cnt_d = '0;
          idx_d      = '0;
          asm_d      = '0;
          wr_addr_d  = '0;
          state_d    = (len_clamp == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (byte_valid) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: asm_d[7:0]   = byte_in;
            2'd1: asm_d[15:8]  = byte_in;
            2'd2: asm_d[23:16] = byte_in;
            default: begin
              wr_data_d = {byte_in, asm_q};
              state_d   = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q + CNT_W'(1) == len_q) begin
            state_d = S_DONE;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            state_d   = S_RECV;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies decoded from the next state.
    byte_ready_d = (state_d == S_RECV);
    wr_en_d      = (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes/done events,
// a negedge monitor pops and compares whenever the DUT strobes wr_en or done.
module tb_imem_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned CW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          abort = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_cnt;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } ev_t;

  ev_t exp_q[$];

  int nchecks = 0;
  int nfail = 0;
  int cyc = 0;
  int wr_total = 0;
  int done_total = 0;
  int wr_cyc_last = 0;
  int wr_cyc_prev = 0;
  int done_cyc = 0;
  bit br_seen = 1'b0;

  logic [7:0] two_b [8] = '{8'h33, 8'h00, 8'hB5, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h40};
  int         gaps  [8] = '{1, 0, 3, 2, 0, 1, 3, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    nchecks++;
    nfail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Monitor: every write/done strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      if (byte_ready) br_seen = 1'b1;
      if (wr_en) begin
        wr_total++;
        wr_cyc_prev = wr_cyc_last;
        wr_cyc_last = cyc;
        if (exp_q.size() == 0) flag_fail("unexpected_write");
        else begin
          e = exp_q.pop_front();
          if (e.is_done) flag_fail("write_before_done");
          else begin
            check("wr_addr", 32'(wr_addr), e.addr);
            check("wr_data", wr_data, e.data);
          end
        end
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
        if (exp_q.size() == 0) flag_fail("unexpected_done");
        else begin
          e = exp_q.pop_front();
          if (!e.is_done) flag_fail("done_before_write");
          else check("done_word_cnt", 32'(word_cnt), e.cnt);
        end
      end
    end
  end

  task automatic exp_wr(input int addr, input logic [31:0] data);
    ev_t e;
    e.is_done = 1'b0; e.addr = 32'(addr); e.data = data; e.cnt = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic exp_done(input int cnt);
    ev_t e;
    e.is_done = 1'b1; e.addr = 32'd0; e.data = 32'd0; e.cnt = 32'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    check({tag, "_wr_data"},    wr_data,         32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_word_cnt"},   32'(word_cnt),   32'd0);
  endtask

  // Called #1 after an edge; returns #1 after the edge that transferred the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 50) begin
        flag_fail("byte_ready_timeout");
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_two(input int first, input int last, input bit gapped);
    for (int i = first; i <= last; i++) send_byte(two_b[i], gapped ? gaps[i] : 0);
  endtask

  task automatic start_session(input int nw);
    start = 1'b1;
    num_words = CW'(nw);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    if (busy) flag_fail("wait_idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0, d0, sc;

    // Reset and idle
    #1;
    check_zero("in_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_zero("idle");

    // Two words, valid held high
    exp_wr(0, 32'h00B5_0033);
    exp_wr(1, 32'h4020_80B3);
    exp_done(2);
    start_session(2);
    check("start_busy", 32'(busy), 32'd1);
    check("start_byte_ready", 32'(byte_ready), 32'd1);
    send_two(0, 7, 1'b0);
    wait_idle();
    check("write_spacing", 32'(wr_cyc_last - wr_cyc_prev), 32'd5);
    check("done_after_write", 32'(done_cyc - wr_cyc_last), 32'd1);
    check("two_word_cnt", 32'(word_cnt), 32'd2);
    check("two_busy", 32'(busy), 32'd0);
    check("two_queue_empty", 32'(exp_q.size()), 32'd0);

    // Same words with idle gaps between bytes
    w0 = wr_total;
    exp_wr(0, 32'h00B5_0033);
    exp_wr(1, 32'h4020_80B3);
    exp_done(2);
    start_session(2);
    send_two(0, 7, 1'b1);
    wait_idle();
    check("gap_write_count", 32'(wr_total - w0), 32'd2);
    check("gap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length session
    w0 = wr_total;
    br_seen = 1'b0;
    exp_done(0);
    start_session(0);
    sc = cyc;
    wait_idle();
    check("len0_done_cycle", 32'(done_cyc - sc), 32'd0);
    check("len0_no_byte_ready", 32'(br_seen), 32'd0);
    check("len0_no_write", 32'(wr_total - w0), 32'd0);
    check("len0_queue_empty", 32'(exp_q.size()), 32'd0);

    // num_words beyond depth clamps to 4 words
    w0 = wr_total;
    exp_wr(0, 32'h1312_1110);
    exp_wr(1, 32'h1716_1514);
    exp_wr(2, 32'h1B1A_1918);
    exp_wr(3, 32'h1F1E_1D1C);
    exp_done(4);
    start_session(7);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 0);
    wait_idle();
    check("clamp_write_count", 32'(wr_total - w0), 32'd4);
    check("clamp_word_cnt", 32'(word_cnt), 32'd4);
    check("clamp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort after one word plus two bytes
    w0 = wr_total;
    d0 = done_total;
    exp_wr(0, 32'h00B5_0033);
    start_session(3);
    send_two(0, 5, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_byte_ready", 32'(byte_ready), 32'd0);
    check("abort_word_cnt", 32'(word_cnt), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("abort_write_count", 32'(wr_total - w0), 32'd1);
    check("abort_no_done", 32'(done_total - d0), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fresh session after abort restarts at address 0
    exp_wr(0, 32'hA1B2_C3D4);
    exp_done(1);
    start_session(1);
    send_byte(8'hD4, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hA1, 0);
    wait_idle();
    check("restart_word_cnt", 32'(word_cnt), 32'd1);
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

    // start and num_words toggled while busy are ignored
    w0 = wr_total;
    exp_wr(0, 32'h00B5_0033);
    exp_wr(1, 32'h4020_80B3);
    exp_done(2);
    start_session(2);
    start = 1'b1;
    num_words = CW'(3);
    send_two(0, 5, 1'b0);
    start = 1'b0;
    send_two(6, 7, 1'b0);
    wait_idle();
    check("busy_start_write_count", 32'(wr_total - w0), 32'd2);
    check("busy_start_word_cnt", 32'(word_cnt), 32'd2);
    check("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of RECV
    start_session(2);
    send_two(0, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    w0 = wr_total;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    byte_in = 8'h5A;
    byte_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 byte_valid = 1'b0;
    check("reset_no_write", 32'(wr_total - w0), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nchecks);
    $fatal(1, "watchdog");
  end

endmodule
